// File: rtl/rpg_pkg.sv
// Shared play-area geometry, player state encoding and position packing helpers.
package rpg_pkg;

  localparam int TILE   = 32;
  localparam int SPRITE = 16;

  localparam int STEP  = 2;
  localparam int X_MIN = 144;
  localparam int X_MAX = 768;
  localparam int Y_MIN = 31;
  localparam int Y_MAX = 495;

  localparam logic [9:0] START_X = 10'd144;
  localparam logic [9:0] START_Y = 10'd31;

  localparam int MAX_HEALTH   = 3;
  localparam int INVULN_TICKS = 60;
  localparam int TMR_W        = 6;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  // Position bus layout is {x[19:10], y[9:0]}.
  function automatic logic [19:0] pack_pos(input logic [9:0] x, input logic [9:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter that stops at zero; used for the invulnerability window.
module tick_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Player position/health controller: per-frame movement with wall and bound gating,
// enemy damage with an invulnerability window, death and respawn.
module player_motion_ctrl
  import rpg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_respawn,
  input  logic        wall_up,
  input  logic        wall_right,
  input  logic        wall_down,
  input  logic        wall_left,
  input  logic        enemy_collide,
  output logic [19:0] position,
  output logic [1:0]  health,
  output logic        hit,
  output logic        invuln,
  output logic        dead
);

  state_t           state_reg, state_next;
  logic [9:0]       x_reg, x_next, y_reg, y_next;
  logic [9:0]       mv_x, mv_y;
  logic [1:0]       health_reg, health_next;
  logic             hit_reg, hit_next;
  logic             tmr_load, tmr_dec, tmr_zero, tmr_expire;
  logic [TMR_W-1:0] tmr_count;

  // Candidate coordinates one step away, widened so a decrement can never wrap silently.
  logic [10:0] x_dec, x_inc, y_dec, y_inc;
  logic        can_up, can_down, can_left, can_right;

  assign x_dec = {1'b0, x_reg} - 11'(STEP);
  assign x_inc = {1'b0, x_reg} + 11'(STEP);
  assign y_dec = {1'b0, y_reg} - 11'(STEP);
  assign y_inc = {1'b0, y_reg} + 11'(STEP);

  assign can_up    = !wall_up    && !y_dec[10] && (y_dec >= 11'(Y_MIN));
  assign can_down  = !wall_down  && (y_inc <= 11'(Y_MAX));
  assign can_left  = !wall_left  && !x_dec[10] && (x_dec >= 11'(X_MIN));
  assign can_right = !wall_right && (x_inc <= 11'(X_MAX));

  // The window ends on the tick that sees the last count; zero is a safety net.
  assign tmr_expire = (tmr_count == TMR_W'(1)) || tmr_zero;

  tick_down_counter #(.W(TMR_W)) u_invuln_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TMR_W'(INVULN_TICKS)),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Single-axis move: highest-priority pressed button wins even when it is blocked.
  always_comb begin
    mv_x = x_reg;
    mv_y = y_reg;
    if (btn_up) begin
      if (can_up) mv_y = y_dec[9:0];
    end else if (btn_down) begin
      if (can_down) mv_y = y_inc[9:0];
    end else if (btn_left) begin
      if (can_left) mv_x = x_dec[9:0];
    end else if (btn_right) begin
      if (can_right) mv_x = x_inc[9:0];
    end
  end

  // Next-state, damage and respawn logic; everything advances only on move_tick.
  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    health_next = health_reg;
    hit_next    = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    if (move_tick) begin
      case (state_reg)
        ST_ALIVE: begin
          x_next = mv_x;
          y_next = mv_y;
          if (enemy_collide) begin
            health_next = health_reg - 2'd1;
            hit_next    = 1'b1;
            if (health_reg == 2'd1) begin
              state_next = ST_DEAD;
            end else begin
              state_next = ST_INVULN;
              tmr_load   = 1'b1;
            end
          end
        end
        ST_INVULN: begin
          x_next  = mv_x;
          y_next  = mv_y;
          tmr_dec = 1'b1;
          if (tmr_expire) state_next = ST_ALIVE;
        end
        ST_DEAD: begin
          if (btn_respawn) begin
            state_next  = ST_ALIVE;
            x_next      = START_X;
            y_next      = START_Y;
            health_next = 2'(MAX_HEALTH);
          end
        end
        default: state_next = ST_ALIVE;
      endcase
    end
  end

  // State, position, health and hit-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_ALIVE;
      x_reg      <= START_X;
      y_reg      <= START_Y;
      health_reg <= 2'(MAX_HEALTH);
      hit_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      health_reg <= health_next;
      hit_reg    <= hit_next;
    end
  end

  assign position = pack_pos(x_reg, y_reg);
  assign health   = health_reg;
  assign hit      = hit_reg;
  assign invuln   = (state_reg == ST_INVULN);
  assign dead     = (state_reg == ST_DEAD);

endmodule
